// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the single-port SRAM controller:
//   - default address/data widths
//   - FSM state encoding (ST_INIT exists only when SRAM_CTRL_INIT_EN is set)
// Configuration macro: SRAM_CTRL_INIT_EN
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int SRAM_CTRL_ADDR_W = 10;
    localparam int SRAM_CTRL_DATA_W = 32;

    typedef enum logic [2:0] {
`ifdef SRAM_CTRL_INIT_EN
        ST_INIT    = 3'd4,
`endif
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_RSP     = 3'd3
    } state_e;

endpackage

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// Request/response front end for an asynchronous single-port SRAM with
// active-low strobes. Writes complete in one cycle and may be issued every
// cycle; reads take two cycles to a registered response that is held until
// the consumer accepts it. Only one read is outstanding at a time.
//
// Configuration macro: SRAM_CTRL_INIT_EN
//   defined   : after reset the controller clears the whole SRAM to zero
//               (one word per cycle) before accepting requests.
//   undefined : controller is ready immediately, INIT_DONE tied high.
//
// Ports
//   CLK, NRST            clock, synchronous active-low reset
//   REQ_VALID/REQ_READY  request handshake (REQ_READY is combinational)
//   REQ_WR, REQ_ADDR, REQ_WDATA  request type, address, write data
//   RSP_VALID/RSP_READY  read response handshake
//   RSP_RDATA            read data
//   INIT_DONE            memory ready for requests
//   SRAM_NCE/NWRT/NOE    registered active-low SRAM strobes
//   SRAM_ADDR, SRAM_DIN  registered SRAM address and write data
//   SRAM_DOUT            SRAM read data
// ---------------------------------------------------------------------------
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_W = SRAM_CTRL_ADDR_W,
    parameter int MEM_DATA_W = SRAM_CTRL_DATA_W
) (
    input  logic                  CLK,
    input  logic                  NRST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WR,
    input  logic [MEM_ADDR_W-1:0] REQ_ADDR,
    input  logic [MEM_DATA_W-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [MEM_DATA_W-1:0] RSP_RDATA,
    output logic                  INIT_DONE,
    output logic                  SRAM_NCE,
    output logic                  SRAM_NWRT,
    output logic                  SRAM_NOE,
    output logic [MEM_ADDR_W-1:0] SRAM_ADDR,
    output logic [MEM_DATA_W-1:0] SRAM_DIN,
    input  logic [MEM_DATA_W-1:0] SRAM_DOUT
);

    state_e                  state_q, state_d;
    logic                    nce_q, nce_d;
    logic                    nwrt_q, nwrt_d;
    logic                    noe_q, noe_d;
    logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
    logic [MEM_DATA_W-1:0]   din_q, din_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [MEM_DATA_W-1:0]   rdata_q, rdata_d;
`ifdef SRAM_CTRL_INIT_EN
    logic [MEM_ADDR_W-1:0]   cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        // Strobes fall back to inactive every cycle; only the current
        // state asserts them, so a write pulse lasts exactly one cycle.
        nce_d       = 1'b1;
        nwrt_d      = 1'b1;
        noe_d       = 1'b1;
        addr_d      = addr_q;
        din_d       = din_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
`ifdef SRAM_CTRL_INIT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
`ifdef SRAM_CTRL_INIT_EN
            ST_INIT: begin
                nce_d  = 1'b0;
                nwrt_d = 1'b0;
                addr_d = cnt_q;
                din_d  = '0;
                cnt_d  = cnt_q + MEM_ADDR_W'(1);
                if (cnt_q == {MEM_ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
                if (REQ_VALID) begin
                    nce_d  = 1'b0;
                    addr_d = REQ_ADDR;
                    if (REQ_WR) begin
                        nwrt_d = 1'b0;
                        din_d  = REQ_WDATA;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                // Chip enable drops here while output enable opens, so the
                // strobes never combine into a write during the read.
                noe_d   = 1'b0;
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rdata_d     = SRAM_DOUT;
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
`ifdef SRAM_CTRL_INIT_EN
            state_q <= ST_INIT;
            cnt_q   <= '0;
`else
            state_q <= ST_IDLE;
`endif
            nce_q       <= 1'b1;
            nwrt_q      <= 1'b1;
            noe_q       <= 1'b1;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
`ifdef SRAM_CTRL_INIT_EN
            cnt_q       <= cnt_d;
`endif
            nce_q       <= nce_d;
            nwrt_q      <= nwrt_d;
            noe_q       <= noe_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign REQ_READY = (state_q == ST_IDLE);
`ifdef SRAM_CTRL_INIT_EN
    assign INIT_DONE = (state_q != ST_INIT);
`else
    assign INIT_DONE = 1'b1;
`endif
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rdata_q;
    assign SRAM_NCE  = nce_q;
    assign SRAM_NWRT = nwrt_q;
    assign SRAM_NOE  = noe_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_DIN  = din_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
// Bench for sram_ctrl with a behavioural asynchronous SRAM behind the SRAM_*
// pins and a word-array reference model of memory contents. Directed cases
// cover write/read latency, back-to-back writes, response back-pressure,
// read-after-write and reset during a read; a randomized phase mixes writes,
// reads and idle cycles. With SRAM_CTRL_INIT_EN defined the power-up clear is
// also exercised.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          CLK;
    logic          NRST;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WR;
    logic [AW-1:0] REQ_ADDR;
    logic [DW-1:0] REQ_WDATA;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic [DW-1:0] RSP_RDATA;
    logic          INIT_DONE;
    logic          SRAM_NCE;
    logic          SRAM_NWRT;
    logic          SRAM_NOE;
    logic [AW-1:0] SRAM_ADDR;
    logic [DW-1:0] SRAM_DIN;
    logic [DW-1:0] SRAM_DOUT;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];

    sram_ctrl #(.MEM_ADDR_W(AW), .MEM_DATA_W(DW)) dut (
        .CLK       (CLK),
        .NRST      (NRST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WR    (REQ_WR),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_RDATA (RSP_RDATA),
        .INIT_DONE (INIT_DONE),
        .SRAM_NCE  (SRAM_NCE),
        .SRAM_NWRT (SRAM_NWRT),
        .SRAM_NOE  (SRAM_NOE),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_DIN  (SRAM_DIN),
        .SRAM_DOUT (SRAM_DOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural SRAM: write on a clock edge with CE and WE low, read
    // data driven whenever output enable is low.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = 32'hC3A5_0000 + i;
            ref_mem[i]  = 32'hC3A5_0000 + i;
        end
    end
    always @(posedge CLK) begin
        if (!SRAM_NCE && !SRAM_NWRT) sram_mem[SRAM_ADDR] = SRAM_DIN;
    end
    assign SRAM_DOUT = !SRAM_NOE ? sram_mem[SRAM_ADDR] : '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output enable must never coincide with a write strobe.
    always @(negedge CLK) begin
        if (NRST && !SRAM_NOE) check("oe_vs_write", {62'd0, SRAM_NCE, SRAM_NWRT} == 0, 0);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_nce"},   SRAM_NCE,  1);
        check({tag, "_nwrt"},  SRAM_NWRT, 1);
        check({tag, "_noe"},   SRAM_NOE,  1);
        check({tag, "_addr"},  SRAM_ADDR, 0);
        check({tag, "_din"},   SRAM_DIN,  0);
        check({tag, "_rvld"},  RSP_VALID, 0);
        check({tag, "_rdata"}, RSP_RDATA, 0);
    endtask

    task automatic write_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
        REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_ADDR = a; REQ_WDATA = d;
        check("wr_ready", REQ_READY, 1);
        tick();
        REQ_VALID = 1'b0;
        check("wr_nce",  SRAM_NCE,  0);
        check("wr_nwrt", SRAM_NWRT, 0);
        check("wr_noe",  SRAM_NOE,  1);
        check("wr_addr", SRAM_ADDR, a);
        check("wr_din",  SRAM_DIN,  d);
        check("wr_stay_idle", REQ_READY, 1);
        ref_mem[a] = d;
    endtask

    task automatic idle_cycle();
        tick();
        check("idle_nce",  SRAM_NCE,  1);
        check("idle_nwrt", SRAM_NWRT, 1);
    endtask

    task automatic read_req(input logic [AW-1:0] a, input int hold);
        logic [DW-1:0] exp;
        exp = ref_mem[a];
        RSP_READY = 1'b0;
        REQ_VALID = 1'b1; REQ_WR = 1'b0; REQ_ADDR = a;
        check("rd_ready", REQ_READY, 1);
        tick();
        REQ_VALID = 1'b0;
        check("rd0_nce",  SRAM_NCE,  0);
        check("rd0_nwrt", SRAM_NWRT, 1);
        check("rd0_addr", SRAM_ADDR, a);
        check("rd0_busy", REQ_READY, 0);
        tick();
        check("rd1_nce",  SRAM_NCE,  1);
        check("rd1_noe",  SRAM_NOE,  0);
        check("rd1_rvld", RSP_VALID, 0);
        check("rd1_busy", REQ_READY, 0);
        tick();
        check("rd2_rvld",  RSP_VALID, 1);
        check("rd2_rdata", RSP_RDATA, exp);
        check("rd2_noe",   SRAM_NOE,  1);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_rvld",  RSP_VALID, 1);
            check("hold_rdata", RSP_RDATA, exp);
            check("hold_busy",  REQ_READY, 0);
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        check("rsp_done_rvld",  RSP_VALID, 0);
        check("rsp_done_ready", REQ_READY, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] a;
        int            op;
        int            n;

        NRST = 1'b0; REQ_VALID = 1'b0; REQ_WR = 1'b0;
        REQ_ADDR = '0; REQ_WDATA = '0; RSP_READY = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
`ifdef SRAM_CTRL_INIT_EN
        check("rst_ready", REQ_READY, 0);
        check("rst_init_done", INIT_DONE, 0);
        NRST = 1'b1;
        n = 0;
        while (!INIT_DONE && n < 2000) begin
            tick();
            n++;
            if (n == 500) begin
                check("init_ready", REQ_READY, 0);
                check("init_nce",   SRAM_NCE,  0);
                check("init_nwrt",  SRAM_NWRT, 0);
                check("init_addr",  SRAM_ADDR, 499);
                check("init_din",   SRAM_DIN,  0);
            end
        end
        check("init_latency", n, 1024);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        read_req(10'h2A7, 0);
`else
        check("rst_ready", REQ_READY, 1);
        check("rst_init_done", INIT_DONE, 1);
        NRST = 1'b1;
        tick();
`endif

        // Simple write then read-back
        write_req(10'h005, 32'hDEAD_BEEF);
        idle_cycle();
        read_req(10'h005, 0);

        // Back-to-back writes, then read-back
        write_req(10'h000, 32'h1111_0000);
        write_req(10'h001, 32'h2222_0001);
        write_req(10'h002, 32'h3333_0002);
        write_req(10'h003, 32'h4444_0003);
        idle_cycle();
        for (int i = 0; i < 4; i++) read_req(AW'(i), 1);

        // Response back-pressure on the top address
        read_req(10'h3FF, 5);

        // Read issued on the cycle right after a write to the same address
        write_req(10'h010, 32'h1234_5678);
        read_req(10'h010, 0);

        // Randomized mix over a small address window
        for (int i = 0; i < 80; i++) begin
            a  = AW'(10'h100 + $urandom_range(0, 15));
            op = $urandom_range(0, 3);
            if (op == 0) begin
                write_req(a, $urandom);
            end else if (op == 1) begin
                write_req(a, $urandom);
                read_req(a, $urandom_range(0, 2));
            end else if (op == 2) begin
                read_req(a, $urandom_range(0, 3));
            end else begin
                idle_cycle();
            end
        end

        // Reset while the read data is being captured
        REQ_VALID = 1'b1; REQ_WR = 1'b0; REQ_ADDR = 10'h005;
        tick();
        REQ_VALID = 1'b0;
        tick();
        NRST = 1'b0;
        tick();
        check_reset_outputs("abort");
        NRST = 1'b1;
        RSP_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_rsp", RSP_VALID, 0);
        end
`ifdef SRAM_CTRL_INIT_EN
        check("abort_init_done", INIT_DONE, 0);
`else
        check("abort_ready", REQ_READY, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
